sequential_array_divider: RTL
=============================

# sequential_array_divider

Iterative unsigned restoring divider. It is the inverse-operation companion of the pipelined array multiplier stages in the integer arithmetic library. It accepts a DATA_WIDTH dividend/divisor pair through a valid handshake and resolves QUOTIENT_PER_CYCLE quotient bits per clock, using a chain of combinational trial-subtract rows between two registers. It returns quotient, remainder and a divide-by-zero flag with a one-cycle completion pulse.

## Interface
- DATA_WIDTH, 8, operand/result width; power of 2, at least 4.
- QUOTIENT_PER_CYCLE, 2, quotient bits resolved per clock; power of 2, at most DATA_WIDTH.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- data_valid_i  input  1  request strobe; sampled only in IDLE.
- dividend_i  input  DATA_WIDTH  unsigned dividend; captured on accept.
- divisor_i  input  DATA_WIDTH  unsigned divisor; captured on accept.
- quotient_o  output  DATA_WIDTH  registered quotient; holds until the next completion.
- remainder_o  output  DATA_WIDTH  registered remainder; holds until the next completion.
- divide_by_zero_o  output  1  registered; set with results when divisor was 0.
- data_valid_o  output  1  one-cycle pulse, high only in DONE.
- idle_o  output  1  high only in IDLE (ready to accept).

## Operation
- Reset (async, immediate): state = IDLE. quotient_o, remainder_o, divide_by_zero_o and data_valid_o are 0. idle_o is 1. Internal registers are cleared.
- Definitions: N = DATA_WIDTH / QUOTIENT_PER_CYCLE iterations. Iteration counter width is clog2(N)+1.
- Registers:
  - partial remainder R: DATA_WIDTH+1 bits.
  - shift register Q: DATA_WIDTH bits, loaded with the dividend and refilled with quotient bits from the LSB.
  - divisor D: DATA_WIDTH bits.
  - counter.
- Restoring row (combinational, chained QUOTIENT_PER_CYCLE times per clock):
  - R' = {R[DATA_WIDTH-1:0], Q[DATA_WIDTH-1]}.
  - Q' = Q << 1.
  - T = R' - {1'b0, D}, computed at DATA_WIDTH+1 bits.
  - If T[DATA_WIDTH] == 0: R = T and Q'[0] = 1. Otherwise R = R' and Q'[0] = 0.
- FSM states and transitions:
  - IDLE: if data_valid_i is high, load Q = dividend_i, D = divisor_i, R = 0, counter = 0.
    - If divisor_i == 0, go to DONE with results preset: quotient all ones, remainder = dividend_i, divide_by_zero = 1.
    - Otherwise go to DIVIDE.
  - DIVIDE: each edge applies QUOTIENT_PER_CYCLE rows and increments the counter. On the edge where the counter reaches N-1:
    - quotient_o = final Q, remainder_o = final R[DATA_WIDTH-1:0], divide_by_zero_o = 0.
    - Go to DONE.
  - DONE: data_valid_o = 1. The next edge always goes to IDLE.
- data_valid_i outside IDLE (DIVIDE or DONE) is ignored; no queuing.
- Inputs are only sampled at the accept edge. Changes to dividend_i/divisor_i afterwards do not affect the result in progress.
- Results: dividend = quotient*divisor + remainder, with remainder < divisor, for every nonzero divisor.

## Timing
- The accept edge is edge 0, i.e. the rising edge at which IDLE samples data_valid_i = 1.
- Normal latency: results update and data_valid_o rises after edge N. data_valid_o falls after edge N+1, when idle_o returns to 1.
  - Example: DATA_WIDTH=8, QUOTIENT_PER_CYCLE=2 gives N=4.
- Divide-by-zero latency: data_valid_o is high in the cycle after edge 0, and idle_o is back to 1 after edge 1.
- Minimum spacing between accepted requests is N+2 edges (N+2 cycles) for a normal division, and 2 edges for divide-by-zero.
- Reset asserted mid-DIVIDE or during DONE: the operation is aborted with no data_valid_o pulse. Outputs return to reset values asynchronously.
- After reset deasserts, the first edge with data_valid_i = 1 is a valid accept.
- The critical path is QUOTIENT_PER_CYCLE chained (DATA_WIDTH+1)-bit subtract/mux rows.

## Test plan
- Defaults, 200/7:
  - accept at edge 0; idle_o drops after edge 0.
  - After edge 4: quotient_o = 28, remainder_o = 4, divide_by_zero_o = 0, data_valid_o = 1 for exactly one cycle.
  - idle_o = 1 after edge 5.
- 55/0:
  - After edge 0: data_valid_o = 1, quotient_o = 0xFF, remainder_o = 55, divide_by_zero_o = 1.
  - Then a following 9/3 gives quotient_o = 3, remainder_o = 0, divide_by_zero_o = 0.
- Boundaries:
  - 255/1 gives 255 rem 0.
  - 5/10 gives 0 rem 5.
  - 255/255 gives 1 rem 0.
  - 0/13 gives 0 rem 0.
  - All complete with latency 4.
- Busy behaviour, 100/9:
  - Hold data_valid_i high continuously with changing operands.
  - Exactly one result, 11 rem 1, is produced per accept.
  - The next request is accepted only when idle_o = 1.
  - Spacing between data_valid_o pulses is 6 cycles.
- Reset mid-operation:
  - Assert rst_i two cycles after accepting 200/7. Outputs go to 0 immediately, idle_o = 1, and no data_valid_o pulse occurs.
  - A subsequent 77/5 yields 15 rem 2.
- Random sweep at DATA_WIDTH=16, QUOTIENT_PER_CYCLE in {1,4,16}:
  - Compare against a reference model.
  - Check latency is 16, 4 and 1 edges respectively.

Source files
------------

// File: rtl/sequential_array_divider.sv
// Iterative unsigned restoring divider: each clock applies QUOTIENT_PER_CYCLE
// chained trial-subtract rows between the partial-remainder and quotient registers.
module sequential_array_divider #(
    parameter int DATA_WIDTH         = 8,
    parameter int QUOTIENT_PER_CYCLE = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  data_valid_i,
    input  logic [DATA_WIDTH-1:0] dividend_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] quotient_o,
    output logic [DATA_WIDTH-1:0] remainder_o,
    output logic                  divide_by_zero_o,
    output logic                  data_valid_o,
    output logic                  idle_o
);

    localparam int N  = DATA_WIDTH / QUOTIENT_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [DATA_WIDTH:0]   rem;
    logic [DATA_WIDTH:0]   rem_next;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] quo_next;
    logic [DATA_WIDTH-1:0] div;
    logic [CW-1:0]         count;
    logic                  last_iter;

    assign last_iter    = (count == LAST);
    assign data_valid_o = (state == DONE);
    assign idle_o       = (state == IDLE);

    // The remainder always stays below the divisor, so the sign bit of the
    // (DATA_WIDTH+1)-bit trial difference alone decides each quotient bit.
    always_comb begin
        logic [DATA_WIDTH:0] shifted;
        logic [DATA_WIDTH:0] trial;
        shifted  = '0;
        trial    = '0;
        rem_next = rem;
        quo_next = quo;
        for (int i = 0; i < QUOTIENT_PER_CYCLE; i++) begin
            shifted  = {rem_next[DATA_WIDTH-1:0], quo_next[DATA_WIDTH-1]};
            quo_next = quo_next << 1;
            trial    = shifted - {1'b0, div};
            if (!trial[DATA_WIDTH]) begin
                rem_next    = trial;
                quo_next[0] = 1'b1;
            end else begin
                rem_next = shifted;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (data_valid_i) begin
                    state_next = (divisor_i == '0) ? DONE : DIVIDE;
                end
            end
            DIVIDE: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rem              <= '0;
            quo              <= '0;
            div              <= '0;
            count            <= '0;
            quotient_o       <= '0;
            remainder_o      <= '0;
            divide_by_zero_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_valid_i) begin
                        quo   <= dividend_i;
                        div   <= divisor_i;
                        rem   <= '0;
                        count <= '0;
                        if (divisor_i == '0) begin
                            quotient_o       <= '1;
                            remainder_o      <= dividend_i;
                            divide_by_zero_o <= 1'b1;
                        end
                    end
                end
                DIVIDE: begin
                    rem   <= rem_next;
                    quo   <= quo_next;
                    count <= count + 1'b1;
                    if (last_iter) begin
                        quotient_o       <= quo_next;
                        remainder_o      <= rem_next[DATA_WIDTH-1:0];
                        divide_by_zero_o <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
